exe_stage_mc: RTL

Parametrised multi-cycle execute stage for the in-order core. It sits between decode and LSU in the pipeline and adds three things: a valid/ready handshake on both sides, an XLEN-generic datapath, and N-source operand forwarding. Shifts can run on an iterative shifter that moves SHIFT_STEP bits per cycle. Branch and jump resolution produce a registered redirect to fetch.

---
 rtl/exe_stage_mc.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: multi-cycle execute stage between decode and LSU.
// Provides valid/ready handshakes on both sides, an XLEN-generic ALU,
// N-source operand forwarding with index 0 as the highest priority,
// and a registered branch/jump redirect to fetch.
// Optional build macro: EXE_ITER_SHIFT_EN. When it is defined, non-zero
// shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle.
// When it is undefined, a single-cycle barrel shifter is used and busy is 0.
module exe_stage_mc #(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 2,
  parameter int SHIFT_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              alu_op,
  input  logic                    opr1_sel,
  input  logic                    opr2_sel,
  input  logic                    cmp_opr2_sel,
  input  logic [2:0]              branch_op,
  input  logic                    branch_req,
  input  logic                    jump_req,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         imm,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [4:0]              rd_addr,
  input  logic                    rd_wr_req,
  input  logic [NUM_FWD-1:0]      fwd_rs1_sel,
  input  logic [NUM_FWD-1:0]      fwd_rs2_sel,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_alu_result,
  output logic [XLEN-1:0]         out_rs2_data,
  output logic [4:0]              out_rd_addr,
  output logic                    out_rd_wr_req,
  output logic                    out_new_pc_req,
  output logic [XLEN-1:0]         out_pc_new,
  output logic                    busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_COPY1 = 4'd10;
  localparam logic [3:0] OP_COPY2 = 4'd11;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LTU  = 3'd5;
  localparam logic [2:0] BR_GEU  = 3'd6;

  // Reject illegal configurations at elaboration time
  if (!((XLEN == 32) || (XLEN == 64))) begin : g_bad_xlen
    $error("exe_stage_mc: XLEN must be 32 or 64");
  end
  if ((SHIFT_STEP < 1) || (SHIFT_STEP > XLEN) ||
      ((SHIFT_STEP & (SHIFT_STEP - 1)) != 0)) begin : g_bad_step
    $error("exe_stage_mc: SHIFT_STEP must be a power of 2 no larger than XLEN");
  end

  // Priority forwarding pick: the lowest-index hit wins, else the decode value.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [NUM_FWD-1:0]      sel,
    input logic [NUM_FWD*XLEN-1:0] data,
    input logic [XLEN-1:0]         dflt
  );
    logic [XLEN-1:0] r;
    r = dflt;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      r = sel[i] ? data[i*XLEN +: XLEN] : r;
    end
    return r;
  endfunction

  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;
  logic [XLEN-1:0] opr1;
  logic [XLEN-1:0] opr2;
  logic [XLEN-1:0] cmp_opr2;
  logic [XLEN:0]   cmp;
  logic            ovf;
  logic            lt;
  logic            ltu;
  logic            eq;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            branch_res;
  logic            new_pc_req;
  logic            accept;

  logic            wr_en;
  logic [XLEN-1:0] wr_result;
  logic [XLEN-1:0] wr_rs2;
  logic [4:0]      wr_rd;
  logic            wr_rd_req;
  logic            wr_pc_req;

  // Resolve forwarded operands, select ALU/compare operands, run the compare
  always_comb begin
    rs1_res  = fwd_pick(fwd_rs1_sel, fwd_data, rs1_data);
    rs2_res  = fwd_pick(fwd_rs2_sel, fwd_data, rs2_data);
    opr1     = opr1_sel ? pc : rs1_res;
    opr2     = opr2_sel ? imm : rs2_res;
    cmp_opr2 = cmp_opr2_sel ? imm : rs2_res;
    cmp      = {1'b0, rs1_res} - {1'b0, cmp_opr2};
    // signed overflow of rs1 - cmp_opr2: operand signs differ and result sign flips
    ovf      = (rs1_res[XLEN-1] ^ cmp_opr2[XLEN-1]) & (cmp[XLEN-1] ^ rs1_res[XLEN-1]);
    lt       = cmp[XLEN-1] ^ ovf;
    ltu      = cmp[XLEN];
    eq       = (cmp[XLEN-1:0] == {XLEN{1'b0}});
    shamt    = opr2[SHW-1:0];
  end

  // Single-cycle ALU result
  always_comb begin
    alu_res = {XLEN{1'b0}};
    case (alu_op)
      OP_ADD:   alu_res = opr1 + opr2;
      OP_SUB:   alu_res = opr1 - opr2;
      OP_AND:   alu_res = opr1 & opr2;
      OP_OR:    alu_res = opr1 | opr2;
      OP_XOR:   alu_res = opr1 ^ opr2;
`ifdef EXE_ITER_SHIFT_EN
      // only a zero shift amount finishes here; others run in the SHIFT state
      OP_SLL:   alu_res = opr1;
      OP_SRL:   alu_res = opr1;
      OP_SRA:   alu_res = opr1;
`else
      OP_SLL:   alu_res = opr1 << shamt;
      OP_SRL:   alu_res = opr1 >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(opr1) >>> shamt);
`endif
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, ltu};
      OP_COPY1: alu_res = opr1;
      OP_COPY2: alu_res = opr2;
      default:  alu_res = {XLEN{1'b0}};
    endcase
  end

  // Branch condition and redirect request
  always_comb begin
    branch_res = 1'b0;
    case (branch_op)
      BR_NONE: branch_res = 1'b0;
      BR_EQ:   branch_res = eq;
      BR_NE:   branch_res = ~eq;
      BR_LT:   branch_res = lt;
      BR_GE:   branch_res = ~lt;
      BR_LTU:  branch_res = ltu;
      BR_GEU:  branch_res = ~ltu;
      default: branch_res = 1'b0;
    endcase
    new_pc_req = jump_req | (branch_req & branch_res);
  end

  assign accept = in_valid & in_ready;

`ifdef EXE_ITER_SHIFT_EN
  localparam int CW = SHW + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          state;
  state_t          nxt_state;
  logic            is_shift;
  logic            start_iter;
  logic            sh_done;
  logic [XLEN-1:0] sh_val;
  logic [XLEN-1:0] sh_val_nxt;
  logic [CW-1:0]   sh_rem;
  logic [CW-1:0]   sh_rem_nxt;
  logic [CW-1:0]   sh_step;
  logic [3:0]      sh_op;
  logic [XLEN-1:0] sh_rs2;
  logic [4:0]      sh_rd;
  logic            sh_rd_req;
  logic            sh_pc_req;

  // An accepted shift with a non-zero amount goes to the iterative shifter
  always_comb begin
    is_shift   = (alu_op == OP_SLL) | (alu_op == OP_SRL) | (alu_op == OP_SRA);
    start_iter = accept & is_shift & (shamt != {SHW{1'b0}});
  end

  // One shifter step of min(SHIFT_STEP, remaining) bits
  always_comb begin
    sh_step    = (sh_rem < CW'(SHIFT_STEP)) ? sh_rem : CW'(SHIFT_STEP);
    sh_rem_nxt = sh_rem - sh_step;
    sh_val_nxt = sh_val;
    case (sh_op)
      OP_SLL:  sh_val_nxt = sh_val << sh_step;
      OP_SRL:  sh_val_nxt = sh_val >> sh_step;
      OP_SRA:  sh_val_nxt = $unsigned($signed(sh_val) >>> sh_step);
      default: sh_val_nxt = sh_val;
    endcase
    sh_done = (state == ST_SHIFT) & (sh_rem_nxt == {CW{1'b0}});
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    nxt_state = state;
    if (flush) begin
      nxt_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_iter) nxt_state = ST_SHIFT;
          else            nxt_state = ST_IDLE;
        end
        ST_SHIFT: begin
          if (sh_done) nxt_state = ST_IDLE;
          else         nxt_state = ST_SHIFT;
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  // Shifter working value, remaining count and the side-band fields of the op
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val    <= {XLEN{1'b0}};
      sh_rem    <= {CW{1'b0}};
      sh_op     <= 4'd0;
      sh_rs2    <= {XLEN{1'b0}};
      sh_rd     <= 5'd0;
      sh_rd_req <= 1'b0;
      sh_pc_req <= 1'b0;
    end else if (start_iter) begin
      sh_val    <= opr1;
      sh_rem    <= {1'b0, shamt};
      sh_op     <= alu_op;
      sh_rs2    <= rs2_res;
      sh_rd     <= rd_addr;
      sh_rd_req <= rd_wr_req;
      sh_pc_req <= new_pc_req;
    end else if (state == ST_SHIFT) begin
      sh_val    <= sh_val_nxt;
      sh_rem    <= sh_rem_nxt;
    end else begin
      sh_val    <= sh_val;
      sh_rem    <= sh_rem;
    end
  end

  // Output-register write source: finished shift or a single-cycle op
  always_comb begin
    wr_en = sh_done | (accept & ~start_iter);
    if (sh_done) begin
      wr_result = sh_val_nxt;
      wr_rs2    = sh_rs2;
      wr_rd     = sh_rd;
      wr_rd_req = sh_rd_req;
      wr_pc_req = sh_pc_req;
    end else begin
      wr_result = alu_res;
      wr_rs2    = rs2_res;
      wr_rd     = rd_addr;
      wr_rd_req = rd_wr_req;
      wr_pc_req = new_pc_req;
    end
  end

  assign in_ready = ~rst & (state == ST_IDLE) & (~out_valid | out_ready);
  assign busy     = (state == ST_SHIFT);
`else
  // Output-register write source: every accepted op completes in one cycle
  always_comb begin
    wr_en     = accept;
    wr_result = alu_res;
    wr_rs2    = rs2_res;
    wr_rd     = rd_addr;
    wr_rd_req = rd_wr_req;
    wr_pc_req = new_pc_req;
  end

  assign in_ready = ~rst & (~out_valid | out_ready);
  assign busy     = 1'b0;
`endif

  // Output register: cleared by reset/flush, loaded on write, drained on out_ready
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid      <= 1'b0;
      out_alu_result <= {XLEN{1'b0}};
      out_rs2_data   <= {XLEN{1'b0}};
      out_rd_addr    <= 5'd0;
      out_rd_wr_req  <= 1'b0;
      out_new_pc_req <= 1'b0;
      out_pc_new     <= {XLEN{1'b0}};
    end else if (wr_en) begin
      out_valid      <= 1'b1;
      out_alu_result <= wr_result;
      out_rs2_data   <= wr_rs2;
      out_rd_addr    <= wr_rd;
      out_rd_wr_req  <= wr_rd_req;
      out_new_pc_req <= wr_pc_req;
      out_pc_new     <= {wr_result[XLEN-1:2], 2'b00};
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end else begin
      out_valid      <= out_valid;
    end
  end

endmodule
